lsu_dmem: RTL and testbench
===========================

LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 Parameter W, default 32, data and address width.
REQ-002 Parameter DEPTH, default 256, number of W-bit memory words (power of two); AW = log2(DEPTH).
REQ-003 clk_i  input  1  single clock, all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 req_valid_i  input  1  MEM-stage access request present.
REQ-006 req_ready_o  output  1  block can accept a request this cycle.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_funct3_i  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr_i  input  W  byte address.
REQ-010 req_wdata_i  input  W  store data, right-aligned.
REQ-011 rsp_valid_o  output  1  one-cycle response strobe.
REQ-012 ld_data_o  output  W  formatted load data, feeds MEM/WB ld_data.
REQ-013 err_o  output  1  response is misaligned/illegal, qualified by rsp_valid_o.
REQ-014 busy_o  output  1  state != IDLE; pipeline stall source.

Function
REQ-015 FSM states IDLE, LOAD_WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-016 Request accepted on a rising edge where req_valid_i & req_ready_o; inputs sampled only then.
REQ-017 Word index = req_addr_i[AW+1:2]; higher address bits ignored (address wraps modulo DEPTH words).
REQ-018 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-019 Illegal: load funct3 in {011,110,111}; store funct3 other than {000,001,010}.
REQ-020 Misaligned or illegal accept: no memory read or write; IDLE -> RESP; err_o = 1 in RESP; ld_data_o unchanged.
REQ-021 Aligned store accept: memory written on the accept edge; IDLE -> RESP; err_o = 0; ld_data_o unchanged.
REQ-022 Store byte enables: SB lane addr[1:0] gets wdata[7:0]; SH lanes {1,0} or {3,2} by addr[1] get wdata[15:0]; SW all lanes; other lanes untouched.
REQ-023 Aligned load accept: word read issued; IDLE -> LOAD_WAIT.
REQ-024 LOAD_WAIT -> RESP unconditionally on next edge; ld_data_o and err_o = 0 registered on that edge.
REQ-025 Load format: B/BU select byte addr[1:0], H/HU select half addr[1]; B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-026 RESP lasts exactly one cycle with rsp_valid_o = 1, then -> IDLE; rsp_valid_o = 0 in all other states.
REQ-027 Latency from accept edge to rsp_valid_o high: store/error 1 cycle, load 2 cycles; back-to-back throughput: store 1 per 2 cycles, load 1 per 3 cycles.
REQ-028 ld_data_o holds last load result until next load completes; err_o holds until next response.
REQ-029 Load from a word stored earlier returns the stored value (read-after-write across requests is coherent).
REQ-030 req_valid_i while not in IDLE is ignored; requester must hold request until accepted.

Reset
REQ-031 rst_i high forces immediately: state IDLE, rsp_valid_o 0, ld_data_o 0, err_o 0, busy_o 0, req_ready_o 1 once released.
REQ-032 Reset during LOAD_WAIT or RESP drops the pending response; no rsp_valid_o after release.
REQ-033 Memory contents are not reset and are retained across reset; a store coinciding with asserted reset is not performed.

Verification
REQ-034 SW 0xDEADBEEF @0x10, then LW @0x10 -> store rsp at +1 cycle err 0; load rsp at +2 cycles, ld_data_o = 0xDEADBEEF.
REQ-035 Word @0x20 = 0x80FF7F01; LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF80FF; LHU @0x20 -> 0x00007F01.
REQ-036 SB 0x12345678 @0x21 over 0x00000000 -> LW @0x20 = 0x00007800; SH 0xAAAA @0x22 -> LW = 0xAAAA7800.
REQ-037 LW @0x02 and SH @0x05 -> rsp_valid_o with err_o = 1 after 1 cycle, memory unchanged, ld_data_o unchanged; load funct3 011 -> err_o = 1.
REQ-038 Wrap: SW 0x11 @ (DEPTH*4 + 0x8) then LW @0x8 -> 0x00000011.
REQ-039 Assert rst_i in LOAD_WAIT -> no rsp_valid_o, ld_data_o = 0, req_ready_o = 1 after release; prior stored data still readable.

Source files
------------

// File: rtl/lsu_dmem.sv
// Load/store unit with a private data memory for the RV32I MEM stage.
// Accepts one request at a time and answers it with a single-cycle response strobe.
// Stores and rejected requests answer one cycle after the accept edge.
// Loads answer two cycles after the accept edge, with the formatted data.
module lsu_dmem #(
  parameter int W     = 32,
  parameter int DEPTH = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_we_i,
  input  logic [2:0]   req_funct3_i,
  input  logic [W-1:0] req_addr_i,
  input  logic [W-1:0] req_wdata_i,
  output logic         rsp_valid_o,
  output logic [W-1:0] ld_data_o,
  output logic         err_o,
  output logic         busy_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP      = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Merge right-aligned store data into the old word; lanes outside the access keep their value.
  function automatic logic [W-1:0] store_merge(input logic [W-1:0] old_word,
                                               input logic [W-1:0] wdata,
                                               input logic [2:0]   f3,
                                               input logic [1:0]   off);
    logic [W-1:0] w;
    w = old_word;
    case (f3)
      F3_B:    w[{off, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    w[{off[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    w = wdata;
      default: w = old_word;
    endcase
    return w;
  endfunction

  // Select the addressed byte/half of a word and sign- or zero-extend it.
  function automatic logic [W-1:0] load_format(input logic [W-1:0] word,
                                               input logic [2:0]   f3,
                                               input logic [1:0]   off);
    logic [7:0]   b;
    logic [15:0]  h;
    logic [W-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    r = {{(W-8){b[7]}}, b};
      F3_BU:   r = {{(W-8){1'b0}}, b};
      F3_H:    r = {{(W-16){h[15]}}, h};
      F3_HU:   r = {{(W-16){1'b0}}, h};
      F3_W:    r = word;
      default: r = word;
    endcase
    return r;
  endfunction

  logic [W-1:0]  mem_r [DEPTH];
  logic [1:0]    state_r;
  logic          ready_r;
  logic          busy_r;
  logic          rsp_valid_r;
  logic [W-1:0]  ld_data_r;
  logic          err_r;
  logic [W-1:0]  rd_word_r;
  logic [2:0]    ld_f3_r;
  logic [1:0]    ld_off_r;

  logic [AW-1:0] idx_s;
  logic [1:0]    off_s;
  logic          accept_s;
  logic          illegal_s;
  logic          misalign_s;
  logic          req_err_s;
  logic          store_go_s;
  logic          load_go_s;
  logic          unused_addr_s;

  // Address bits above the memory are deliberately dropped so accesses wrap modulo DEPTH words.
  assign idx_s         = req_addr_i[AW+1:2];
  assign off_s         = req_addr_i[1:0];
  assign unused_addr_s = ^req_addr_i[W-1:AW+2];

  assign accept_s   = req_valid_i & (state_r == ST_IDLE);
  assign req_err_s  = illegal_s | misalign_s;
  assign store_go_s = accept_s & ~req_err_s & req_we_i;
  assign load_go_s  = accept_s & ~req_err_s & ~req_we_i;

  // Classify the incoming request as illegal (unknown width code) or misaligned.
  always_comb begin
    illegal_s  = 1'b0;
    misalign_s = 1'b0;
    if (req_we_i) begin
      case (req_funct3_i)
        F3_B, F3_H, F3_W: illegal_s = 1'b0;
        default:          illegal_s = 1'b1;
      endcase
    end else begin
      case (req_funct3_i)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_s = 1'b0;
        default:                        illegal_s = 1'b1;
      endcase
    end
    case (req_funct3_i)
      F3_H, F3_HU: misalign_s = off_s[0];
      F3_W:        misalign_s = (off_s != 2'b00);
      default:     misalign_s = 1'b0;
    endcase
  end

  // Memory array: write on an accepted store, read the word of an accepted load; never while reset is high.
  always_ff @(posedge clk_i) begin
    if (!rst_i && store_go_s) begin
      mem_r[idx_s] <= store_merge(mem_r[idx_s], req_wdata_i, req_funct3_i, off_s);
    end
    if (!rst_i && load_go_s) begin
      rd_word_r <= mem_r[idx_s];
    end
  end

  // Control FSM with registered response, status and load-data outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      ld_data_r   <= {W{1'b0}};
      err_r       <= 1'b0;
      ld_f3_r     <= 3'b000;
      ld_off_r    <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            if (req_err_s || req_we_i) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              err_r       <= req_err_s;
            end else begin
              state_r     <= ST_LOAD_WAIT;
              rsp_valid_r <= 1'b0;
              ld_f3_r     <= req_funct3_i;
              ld_off_r    <= off_s;
            end
          end else begin
            rsp_valid_r <= 1'b0;
          end
        end
        ST_LOAD_WAIT: begin
          state_r     <= ST_RESP;
          rsp_valid_r <= 1'b1;
          err_r       <= 1'b0;
          ld_data_r   <= load_format(rd_word_r, ld_f3_r, ld_off_r);
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          ready_r     <= 1'b1;
          busy_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          ready_r     <= 1'b1;
          busy_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_r;
  assign busy_o      = busy_r;
  assign rsp_valid_o = rsp_valid_r;
  assign ld_data_o   = ld_data_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_lsu_dmem.sv
// Self-checking bench for lsu_dmem: directed vectors plus random requests
// checked against a byte-array memory model.
module tb_lsu_dmem;

  localparam int W     = 32;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [W-1:0]  req_addr;
  logic [W-1:0]  req_wdata;
  logic          rsp_valid;
  logic [W-1:0]  ld_data;
  logic          err;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem_m [DEPTH*4];
  logic [31:0] ld_m;

  lsu_dmem #(.W(W), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .ld_data_o    (ld_data),
    .err_o        (err),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic exp_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic ill;
    logic mis;
    if (we) ill = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && (addr % 4 != 0));
    return ill | mis;
  endfunction

  function automatic int base_of(input logic [31:0] addr);
    return int'((addr / 32'd4) % DEPTH) * 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int b;
    int o;
    int hb;
    logic [31:0] v;
    b  = base_of(addr);
    o  = int'(addr % 32'd4);
    hb = b + (o / 2) * 2;
    case (f3)
      3'd0: begin
        v = 32'(mem_m[b+o]);
        if (v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'd4: v = 32'(mem_m[b+o]);
      3'd1: begin
        v = 32'(mem_m[hb]) + 32'd256 * 32'(mem_m[hb+1]);
        if (v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      3'd5: v = 32'(mem_m[hb]) + 32'd256 * 32'(mem_m[hb+1]);
      default: v = 32'(mem_m[b]) + 32'd256 * 32'(mem_m[b+1]) +
                   32'd65536 * 32'(mem_m[b+2]) + 32'd16777216 * 32'(mem_m[b+3]);
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int b;
    int o;
    int hb;
    b  = base_of(addr);
    o  = int'(addr % 32'd4);
    hb = b + (o / 2) * 2;
    case (f3)
      3'd0: mem_m[b+o] = wd[7:0];
      3'd1: begin
        mem_m[hb]   = wd[7:0];
        mem_m[hb+1] = wd[15:8];
      end
      default: begin
        mem_m[b]   = wd[7:0];
        mem_m[b+1] = wd[15:8];
        mem_m[b+2] = wd[23:16];
        mem_m[b+3] = wd[31:24];
      end
    endcase
  endtask

  // Drive one request from IDLE, measure cycles to the response strobe, then let the DUT return to IDLE.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output logic e, output logic [31:0] d);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    e   = 1'bx;
    d   = 'x;
    for (int i = 1; i <= 8; i++) begin
      if (rsp_valid === 1'b1) begin
        lat = i;
        e   = err;
        d   = ld_data;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({rsp_valid, err, busy, ld_data} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: rsp=%b err=%b busy=%b ld=%h, required 0 0 0 00000000",
               rsp_valid, err, busy, ld_data);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b busy=%b, required 1 0", req_ready, busy);
    end
    ld_m = 32'h0;
  endtask

  task automatic test_init();
    int lat;
    logic e;
    logic [31:0] d;
    logic [31:0] wd;
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      issue(1'b1, 3'd2, 32'(i * 4), wd, lat, e, d);
      model_store(3'd2, 32'(i * 4), wd);
      if (lat !== 1 || e !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL init_stores: %0d bad responses, required 0", bad);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        e;
    logic [31:0] dat;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic e, input logic [31:0] dat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.e = e; v.dat = dat;
    return v;
  endfunction

  task automatic test_spec_vectors();
    vec_t q[$];
    int lat;
    int exp_lat;
    logic e;
    logic [31:0] d;
    logic [31:0] exp_d;
    q.push_back(mk(1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 0));
    q.push_back(mk(0, 3'd2, 32'h10, 0, 0, 32'hDEAD_BEEF));
    q.push_back(mk(1, 3'd2, 32'h20, 32'h80FF_7F01, 0, 0));
    q.push_back(mk(0, 3'd0, 32'h23, 0, 0, 32'hFFFF_FF80));
    q.push_back(mk(0, 3'd4, 32'h23, 0, 0, 32'h0000_0080));
    q.push_back(mk(0, 3'd1, 32'h22, 0, 0, 32'hFFFF_80FF));
    q.push_back(mk(0, 3'd5, 32'h20, 0, 0, 32'h0000_7F01));
    q.push_back(mk(0, 3'd0, 32'h20, 0, 0, 32'h0000_0001));
    q.push_back(mk(1, 3'd2, 32'h20, 32'h0, 0, 0));
    q.push_back(mk(1, 3'd0, 32'h21, 32'h1234_5678, 0, 0));
    q.push_back(mk(0, 3'd2, 32'h20, 0, 0, 32'h0000_7800));
    q.push_back(mk(1, 3'd1, 32'h22, 32'h0000_AAAA, 0, 0));
    q.push_back(mk(0, 3'd2, 32'h20, 0, 0, 32'hAAAA_7800));
    q.push_back(mk(1, 3'd2, 32'h04, 32'h5555_1234, 0, 0));
    q.push_back(mk(0, 3'd2, 32'h02, 0, 1, 0));
    q.push_back(mk(1, 3'd1, 32'h05, 32'hFFFF_FFFF, 1, 0));
    q.push_back(mk(0, 3'd3, 32'h04, 0, 1, 0));
    q.push_back(mk(1, 3'd4, 32'h04, 32'hFFFF_FFFF, 1, 0));
    q.push_back(mk(0, 3'd2, 32'h04, 0, 0, 32'h5555_1234));
    q.push_back(mk(1, 3'd2, 32'(DEPTH * 4 + 8), 32'h11, 0, 0));
    q.push_back(mk(0, 3'd2, 32'h08, 0, 0, 32'h0000_0011));
    foreach (q[i]) begin
      issue(q[i].we, q[i].f3, q[i].addr, q[i].wd, lat, e, d);
      exp_lat = (q[i].e || q[i].we) ? 1 : 2;
      exp_d   = (q[i].e || q[i].we) ? ld_m : q[i].dat;
      n_checks++;
      if (lat !== exp_lat || e !== q[i].e || d !== exp_d) begin
        n_fail++;
        $display("FAIL vector_%0d: lat=%0d err=%b ld=%h, required lat=%0d err=%b ld=%h",
                 i, lat, e, d, exp_lat, q[i].e, exp_d);
      end
      if (!q[i].e && q[i].we) model_store(q[i].f3, q[i].addr, q[i].wd);
      ld_m = exp_d;
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int exp_pulses;
    logic [31:0] wd;
    for (int k = 0; k < 2; k++) begin
      wd = $urandom;
      req_valid  = 1'b1;
      req_we     = (k == 0);
      req_funct3 = 3'd2;
      req_addr   = 32'h40;
      req_wdata  = wd;
      if (k == 0) model_store(3'd2, 32'h40, wd);
      pulses = 0;
      for (int c = 1; c <= 9; c++) begin
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) pulses++;
      end
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      // latency L, period P over 9 sampled edges
      exp_pulses = (k == 0) ? ((9 - 1) / 2 + 1) : ((9 - 2) / 3 + 1);
      n_checks++;
      if (pulses !== exp_pulses) begin
        n_fail++;
        $display("FAIL back_to_back_%s: %0d responses, required %0d",
                 (k == 0) ? "store" : "load", pulses, exp_pulses);
      end
    end
    ld_m = model_load(3'd2, 32'h40);
    n_checks++;
    if (ld_data !== ld_m) begin
      n_fail++;
      $display("FAIL back_to_back_data: ld=%h, required %h", ld_data, ld_m);
    end
  endtask

  task automatic test_reset_in_load();
    int lat;
    int seen;
    logic e;
    logic [31:0] d;
    logic [31:0] exp_d;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wait_busy: busy=%b ready=%b, required 1 0", busy, req_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, err, busy, ld_data} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: rsp=%b err=%b busy=%b ld=%h, required 0 0 0 00000000",
               rsp_valid, err, busy, ld_data);
    end
    // a store presented while reset is high must not land
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    ld_m = 32'h0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || req_ready !== 1'b1 || ld_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_drop: %0d responses ready=%b ld=%h, required 0 1 00000000",
               seen, req_ready, ld_data);
    end
    for (int k = 0; k < 2; k++) begin
      exp_d = model_load(3'd2, (k == 0) ? 32'h10 : 32'h30);
      issue(1'b0, 3'd2, (k == 0) ? 32'h10 : 32'h30, 32'h0, lat, e, d);
      n_checks++;
      if (lat !== 2 || e !== 1'b0 || d !== exp_d) begin
        n_fail++;
        $display("FAIL retained_%0d: lat=%0d err=%b ld=%h, required 2 0 %h", k, lat, e, d, exp_d);
      end
      ld_m = exp_d;
    end
  endtask

  task automatic test_random();
    int lat;
    int exp_lat;
    logic e;
    logic exp_e;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [31:0] wd;
    for (int i = 0; i < 400; i++) begin
      we   = $urandom_range(1, 0) == 1;
      f3   = 3'($urandom_range(7, 0));
      addr = $urandom;
      if ($urandom_range(3, 0) == 0) addr = 32'($urandom_range(63, 0));
      wd   = $urandom;
      exp_e   = exp_error(we, f3, addr);
      exp_lat = (exp_e || we) ? 1 : 2;
      exp_d   = (exp_e || we) ? ld_m : model_load(f3, addr);
      issue(we, f3, addr, wd, lat, e, d);
      n_checks++;
      if (lat !== exp_lat || e !== exp_e || d !== exp_d) begin
        n_fail++;
        $display("FAIL random_%0d we=%b f3=%0d addr=%h: lat=%0d err=%b ld=%h, required lat=%0d err=%b ld=%h",
                 i, we, f3, addr, lat, e, d, exp_lat, exp_e, exp_d);
      end
      if (!exp_e && we) model_store(f3, addr, wd);
      ld_m = exp_d;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_spec_vectors();
    test_back_to_back();
    test_reset_in_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
